instruction_cycle_engine: RTL and testbench

Parametrised successor to the fixed 8-bit IR/PC/RAM instruction datapath. It adds its own fetch/decode/execute FSM, an accumulator and an 8-opcode instruction set. It also adds a program-load port, so the block is a self-contained microcontroller core for the FPGA board designs.
Each instruction word is {opcode[2:0], address[ADDR_W-1:0]}. The embedded RAM holds both program and data.

---
 rtl/instruction_cycle_engine.sv | 245 ++++++++++++++++++++++++
 tb/tb_instruction_cycle_engine.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_cycle_engine.sv
// instruction_cycle_engine
//   Small accumulator microcontroller core: fetch/decode/execute FSM, PC, IR,
//   accumulator A and an embedded RAM that holds both program and data.
//   Instruction word = {opcode[2:0], address[ADDR_W-1:0]}.
//   Opcodes: 0 LOAD, 1 STORE, 2 ADD, 3 SUB, 4 INPUT, 5 JZ, 6 JPOS, 7 HALT.
//
//   Optional feature macro: SINGLE_STEP_EN
//     Adds the i_step input, a 2-flop synchroniser with rising-edge detect and
//     a PAUSE state. FETCH is entered from START or EXEC only on a step edge.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset (RAM contents survive it)
//   i_step       (SINGLE_STEP_EN only) single-step pushbutton level
//   i_run        level; START -> FETCH when high
//   i_prog_we    program-load write strobe (honoured in START and HALT only)
//   i_prog_addr  program-load address
//   i_prog_data  program-load data
//   i_enter      level; completes an INPUT instruction
//   i_input      value loaded into A by INPUT
//   o_output     A delayed by one clock
//   o_halt       high while in HALT
//   o_pc_dbg     current PC
//   o_state_dbg  current FSM state encoding
//
// Handshake: there are no valid/ready pairs. i_run and i_enter are plain
// levels sampled on the rising edge while the FSM waits in START or EXEC.
module instruction_cycle_engine #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef SINGLE_STEP_EN
  input  logic              i_step,
`endif
  input  logic              i_run,
  input  logic              i_prog_we,
  input  logic [ADDR_W-1:0] i_prog_addr,
  input  logic [DATA_W-1:0] i_prog_data,
  input  logic              i_enter,
  input  logic [DATA_W-1:0] i_input,
  output logic [DATA_W-1:0] o_output,
  output logic              o_halt,
  output logic [ADDR_W-1:0] o_pc_dbg,
  output logic [2:0]        o_state_dbg
);

  localparam int DEPTH = 1 << ADDR_W;

  if (DATA_W != ADDR_W + 3) begin : g_width_check
    $error("instruction_cycle_engine: DATA_W must equal ADDR_W + 3");
  end

  typedef enum logic [2:0] {
    S_START  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
`ifdef SINGLE_STEP_EN
    , S_PAUSE = 3'd5
`endif
  } state_t;

  localparam logic [2:0] OP_LOAD  = 3'd0;
  localparam logic [2:0] OP_STORE = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_SUB   = 3'd3;
  localparam logic [2:0] OP_INPUT = 3'd4;
  localparam logic [2:0] OP_JZ    = 3'd5;
  localparam logic [2:0] OP_JPOS  = 3'd6;
  localparam logic [2:0] OP_HALT  = 3'd7;

  state_t              r_state;
  state_t              w_state_nxt;
  state_t              w_after_exec;
  logic [ADDR_W-1:0]   r_pc;
  logic [DATA_W-1:0]   r_ir;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_output;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic [2:0]          w_opcode;
  logic [ADDR_W-1:0]   w_ir_addr;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_rdata;
  logic                w_ir_load;
  logic                w_pc_inc;
  logic                w_pc_jump;
  logic                w_a_load;
  logic [DATA_W-1:0]   w_a_nxt;
  logic                w_mem_we;
  logic [DATA_W-1:0]   w_mem_wdata;

  assign w_opcode  = r_ir[DATA_W-1:ADDR_W];
  assign w_ir_addr = r_ir[ADDR_W-1:0];

  // One address mux serves both the read port and the write port: the load
  // port owns the RAM while idle, the operand field while executing, and
  // the PC while fetching.
  always_comb begin
    w_addr = r_pc;
    if (r_state == S_START || r_state == S_HALT) begin
      w_addr = i_prog_addr;
    end else if (r_state == S_EXEC) begin
      w_addr = w_ir_addr;
    end
  end

  assign w_rdata = r_mem[w_addr];

`ifdef SINGLE_STEP_EN
  logic r_step_s1;
  logic r_step_s2;
  logic r_step_d;
  logic w_step_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step_s1 <= 1'b0;
      r_step_s2 <= 1'b0;
      r_step_d  <= 1'b0;
    end else begin
      r_step_s1 <= i_step;
      r_step_s2 <= r_step_s1;
      r_step_d  <= r_step_s2;
    end
  end

  assign w_step_edge  = r_step_s2 & ~r_step_d;
  assign w_after_exec = w_step_edge ? S_FETCH : S_PAUSE;
`else
  assign w_after_exec = S_FETCH;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_ir_load   = 1'b0;
    w_pc_inc    = 1'b0;
    w_pc_jump   = 1'b0;
    w_a_load    = 1'b0;
    w_a_nxt     = r_a;
    w_mem_we    = 1'b0;
    w_mem_wdata = i_prog_data;
    case (r_state)
      S_START: begin
        w_mem_we = i_prog_we;
        if (i_run) begin
          w_state_nxt = w_after_exec;
        end
      end
      S_FETCH: begin
        w_ir_load   = 1'b1;
        w_pc_inc    = 1'b1;
        w_state_nxt = S_DECODE;
      end
      S_DECODE: begin
        w_state_nxt = (w_opcode == OP_HALT) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        w_state_nxt = w_after_exec;
        case (w_opcode)
          OP_LOAD: begin
            w_a_load = 1'b1;
            w_a_nxt  = w_rdata;
          end
          OP_STORE: begin
            w_mem_we    = 1'b1;
            w_mem_wdata = r_a;
          end
          OP_ADD: begin
            w_a_load = 1'b1;
            w_a_nxt  = r_a + w_rdata;
          end
          OP_SUB: begin
            w_a_load = 1'b1;
            w_a_nxt  = r_a - w_rdata;
          end
          OP_INPUT: begin
            if (i_enter) begin
              w_a_load = 1'b1;
              w_a_nxt  = i_input;
            end else begin
              w_state_nxt = S_EXEC;
            end
          end
          OP_JZ:   w_pc_jump = (r_a == '0);
          // Strictly positive: sign bit clear and not zero.
          OP_JPOS: w_pc_jump = !r_a[DATA_W-1] && (r_a != '0);
          default: ;
        endcase
      end
      S_HALT: begin
        w_mem_we = i_prog_we;
      end
`ifdef SINGLE_STEP_EN
      S_PAUSE: begin
        if (w_step_edge) begin
          w_state_nxt = S_FETCH;
        end
      end
`endif
      default: w_state_nxt = S_START;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_START;
      r_pc     <= '0;
      r_ir     <= '0;
      r_a      <= '0;
      r_output <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_output <= r_a;
      if (w_ir_load) begin
        r_ir <= w_rdata;
      end
      if (w_pc_jump) begin
        r_pc <= w_ir_addr;
      end else if (w_pc_inc) begin
        r_pc <= r_pc + 1'b1;
      end
      if (w_a_load) begin
        r_a <= w_a_nxt;
      end
    end
  end

  // RAM has no reset. Reset forces the FSM to START, so an in-flight STORE
  // can never reach this write port.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_addr] <= w_mem_wdata;
    end
  end

  assign o_output    = r_output;
  assign o_halt      = (r_state == S_HALT);
  assign o_pc_dbg    = r_pc;
  assign o_state_dbg = r_state;

endmodule

// File: tb/tb_instruction_cycle_engine.sv
module tb_instruction_cycle_engine;
  localparam int AW = 5;
  localparam int DW = 8;
  localparam int W  = 1 + AW + DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_run;
  logic          i_prog_we;
  logic [AW-1:0] i_prog_addr;
  logic [DW-1:0] i_prog_data;
  logic          i_enter;
  logic [DW-1:0] i_input;
  logic [DW-1:0] o_output;
  logic          o_halt;
  logic [AW-1:0] o_pc_dbg;
  logic [2:0]    o_state_dbg;
`ifdef SINGLE_STEP_EN
  logic          i_step;
`endif

  int checks = 0;
  int errors = 0;

  // Instruction-level reference model
  logic [DW-1:0] m_mem [32];
  logic [AW-1:0] m_pc;
  logic [DW-1:0] m_a;
  bit            m_halted;

  // Scoreboard entries are {halt, pc, output}
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];

  instruction_cycle_engine #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef SINGLE_STEP_EN
    .i_step      (i_step),
`endif
    .i_run       (i_run),
    .i_prog_we   (i_prog_we),
    .i_prog_addr (i_prog_addr),
    .i_prog_data (i_prog_data),
    .i_enter     (i_enter),
    .i_input     (i_input),
    .o_output    (o_output),
    .o_halt      (o_halt),
    .o_pc_dbg    (o_pc_dbg),
    .o_state_dbg (o_state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic do_reset();
    i_prog_we = 1'b0;
    i_run     = 1'b0;
    i_enter   = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    m_pc      = '0;
    m_a       = '0;
    m_halted  = 1'b0;
  endtask

  // ---------------- drivers ----------------
  // Advance one clock; optionally spray random load-port writes, which the
  // core must ignore outside START/HALT.
  task automatic adv(input bit noise);
    @(negedge clk);
    i_run = 1'b0;
    if (noise) begin
      i_prog_we   = 1'($urandom_range(1, 0));
      i_prog_addr = AW'($urandom);
      i_prog_data = DW'($urandom);
    end else begin
      i_prog_we = 1'b0;
    end
  endtask

  task automatic load_word(input logic [AW-1:0] addr, input logic [DW-1:0] data, input bit go);
    i_prog_we   = 1'b1;
    i_prog_addr = addr;
    i_prog_data = data;
    i_run       = go;
    m_mem[addr] = data;
    adv(1'b0);
  endtask

  task automatic sample(input bit h, input logic [AW-1:0] pc, input logic [DW-1:0] out);
    exp_q.push_back({h, pc, out});
    got_q.push_back({o_halt, o_pc_dbg, o_output});
  endtask

  // Execute up to max_instr instructions on the model, stepping the DUT the
  // documented number of cycles per instruction and sampling at each
  // instruction boundary. fixed_in < 0 means random INPUT values.
  task automatic run_prog(input int max_instr, input bit started, input bit noise,
                          input int max_dly, input int fixed_in);
    logic [DW-1:0] ir;
    logic [DW-1:0] a_prev;
    logic [DW-1:0] in_v;
    logic [AW-1:0] ad;
    int d;
    if (!started) begin
      i_prog_we = 1'b0;
      i_run     = 1'b1;
      adv(noise);
    end
    for (int k = 0; k < max_instr && !m_halted; k++) begin
      ir     = m_mem[m_pc];
      ad     = ir[AW-1:0];
      m_pc   = m_pc + 1'b1;
      a_prev = m_a;
      case (ir[DW-1:AW])
        3'd7: begin
          adv(noise);
          adv(noise);
          i_prog_we = 1'b0;
          m_halted  = 1'b1;
          sample(1'b1, m_pc, m_a);
        end
        3'd4: begin
          in_v = (fixed_in < 0) ? DW'($urandom) : DW'(fixed_in);
          d    = $urandom_range(max_dly, 0);
          adv(noise);
          adv(noise);
          repeat (d) adv(noise);
          i_input = in_v;
          i_enter = 1'b1;
          adv(noise);
          i_enter = 1'b0;
          m_a = in_v;
          sample(1'b0, m_pc, a_prev);
        end
        default: begin
          case (ir[DW-1:AW])
            3'd0: m_a = m_mem[ad];
            3'd1: m_mem[ad] = m_a;
            3'd2: m_a = m_a + m_mem[ad];
            3'd3: m_a = m_a - m_mem[ad];
            3'd5: if (m_a == 0) m_pc = ad;
            3'd6: if (m_a != 0 && m_a < 8'h80) m_pc = ad;
            default: ;
          endcase
          repeat (3) adv(noise);
          sample(1'b0, m_pc, a_prev);
        end
      endcase
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (o_output !== 8'h00) begin errors++; $display("FAIL reset_output got %h want 00", o_output); end
    checks++; if (o_halt !== 1'b0) begin errors++; $display("FAIL reset_halt got %b want 0", o_halt); end
    checks++; if (o_pc_dbg !== 5'd0) begin errors++; $display("FAIL reset_pc got %0d want 0", o_pc_dbg); end
    rst_n = 1'b1;
    repeat (4) adv(1'b0);
    checks++; if (o_pc_dbg !== 5'd0 || o_halt !== 1'b0) begin
      errors++; $display("FAIL start_idle got pc=%0d halt=%b want pc=0 halt=0", o_pc_dbg, o_halt);
    end
  endtask

  task automatic test_program_a();
    logic [W-1:0] e, g;
    do_reset();
    load_word(5'd1, 8'h3E, 1'b0);
    load_word(5'd2, 8'h5E, 1'b0);
    load_word(5'd3, 8'hE0, 1'b0);
    // Last word written on the same edge that leaves START; FETCH must see it.
    load_word(5'd0, 8'h80, 1'b1);
    run_prog(10, 1'b1, 1'b0, 2, 5);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL prog_a_step got %h want %h", g, e); end
    end
    checks++; if (o_output !== 8'h0A || o_halt !== 1'b1 || o_pc_dbg !== 5'd4) begin
      errors++; $display("FAIL prog_a_final got out=%h halt=%b pc=%0d want 0a 1 4", o_output, o_halt, o_pc_dbg);
    end
    // Load port works in HALT; Run is ignored there.
    load_word(5'd0, 8'h1E, 1'b1);
    load_word(5'd1, 8'hE0, 1'b1);
    i_run = 1'b1;
    repeat (3) @(negedge clk);
    i_run = 1'b0;
    checks++; if (o_halt !== 1'b1 || o_pc_dbg !== 5'd4) begin
      errors++; $display("FAIL halt_hold got halt=%b pc=%0d want 1 4", o_halt, o_pc_dbg);
    end
    do_reset();
    run_prog(5, 1'b0, 1'b0, 0, -1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL ram30_step got %h want %h", g, e); end
    end
    checks++; if (o_output !== 8'h05) begin errors++; $display("FAIL ram30_value got %h want 05", o_output); end
  endtask

  task automatic test_jz();
    logic [W-1:0] e, g;
    do_reset();
    load_word(5'd0, 8'h1F, 1'b0);
    load_word(5'd1, 8'h7F, 1'b0);
    load_word(5'd2, 8'hA5, 1'b0);
    load_word(5'd3, 8'hE0, 1'b0);
    load_word(5'd4, 8'hE0, 1'b0);
    load_word(5'd5, 8'hE0, 1'b0);
    load_word(5'd31, 8'h03, 1'b0);
    run_prog(10, 1'b0, 1'b0, 0, -1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL jz_step got %h want %h", g, e); end
    end
    checks++; if (o_output !== 8'h00 || o_halt !== 1'b1 || o_pc_dbg !== 5'd6) begin
      errors++; $display("FAIL jz_final got out=%h halt=%b pc=%0d want 00 1 6", o_output, o_halt, o_pc_dbg);
    end
  endtask

  task automatic test_sub_jpos();
    logic [W-1:0] e, g;
    do_reset();
    load_word(5'd0, 8'h74, 1'b0);
    load_word(5'd1, 8'hCA, 1'b0);
    load_word(5'd2, 8'hE0, 1'b0);
    load_word(5'd10, 8'hE0, 1'b0);
    load_word(5'd20, 8'h01, 1'b0);
    run_prog(10, 1'b0, 1'b0, 0, -1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL jpos_step got %h want %h", g, e); end
    end
    checks++; if (o_output !== 8'hFF || o_halt !== 1'b1 || o_pc_dbg !== 5'd3) begin
      errors++; $display("FAIL jpos_final got out=%h halt=%b pc=%0d want ff 1 3", o_output, o_halt, o_pc_dbg);
    end
  endtask

  task automatic test_pc_wrap();
    logic [W-1:0] e, g;
    do_reset();
    for (int i = 0; i < 32; i++) load_word(AW'(i), 8'h00, 1'b0);
    run_prog(34, 1'b0, 1'b0, 0, -1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL wrap_step got %h want %h", g, e); end
    end
    checks++; if (o_halt !== 1'b0 || o_pc_dbg !== 5'd2 || o_output !== 8'h00) begin
      errors++; $display("FAIL wrap_final got halt=%b pc=%0d out=%h want 0 2 00", o_halt, o_pc_dbg, o_output);
    end
  endtask

  task automatic test_input_abort();
    logic [W-1:0] e, g;
    do_reset();
    load_word(5'd0, 8'h80, 1'b0);
    load_word(5'd1, 8'h3E, 1'b0);
    load_word(5'd2, 8'h5E, 1'b0);
    load_word(5'd3, 8'hE0, 1'b0);
    i_enter = 1'b0;
    i_input = 8'h77;
    i_run   = 1'b1;
    repeat (3) adv(1'b0);
    repeat (20) adv(1'b0);
    checks++; if (o_halt !== 1'b0 || o_pc_dbg !== 5'd1 || o_output !== 8'h00) begin
      errors++; $display("FAIL input_wait got halt=%b pc=%0d out=%h want 0 1 00", o_halt, o_pc_dbg, o_output);
    end
    do_reset();
    checks++; if (o_halt !== 1'b0 || o_pc_dbg !== 5'd0 || o_output !== 8'h00) begin
      errors++; $display("FAIL abort_reset got halt=%b pc=%0d out=%h want 0 0 00", o_halt, o_pc_dbg, o_output);
    end
    repeat (3) adv(1'b0);
    checks++; if (o_pc_dbg !== 5'd0) begin errors++; $display("FAIL abort_start got pc=%0d want 0", o_pc_dbg); end
    run_prog(10, 1'b0, 1'b0, 0, 5);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL rerun_step got %h want %h", g, e); end
    end
    checks++; if (o_output !== 8'h0A || o_halt !== 1'b1 || o_pc_dbg !== 5'd4) begin
      errors++; $display("FAIL rerun_final got out=%h halt=%b pc=%0d want 0a 1 4", o_output, o_halt, o_pc_dbg);
    end
  endtask

  task automatic test_random_programs();
    logic [W-1:0] e, g;
    for (int t = 0; t < 6; t++) begin
      do_reset();
      for (int i = 0; i < 32; i++) load_word(AW'(i), DW'($urandom), 1'b0);
      run_prog(40, 1'b0, 1'b1, 3, -1);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
        if (g !== e) begin errors++; $display("FAIL random_prog%0d got %h want %h", t, g, e); end
      end
    end
    do_reset();
  endtask

`ifdef SINGLE_STEP_EN
  task automatic test_single_step();
    do_reset();
    load_word(5'd1, 8'h3E, 1'b0);
    load_word(5'd2, 8'h5E, 1'b0);
    load_word(5'd3, 8'hE0, 1'b0);
    load_word(5'd0, 8'h80, 1'b0);
    i_enter = 1'b1;
    i_input = 8'h05;
    i_run   = 1'b1;
    adv(1'b0);
    repeat (5) adv(1'b0);
    checks++; if (o_pc_dbg !== 5'd0) begin errors++; $display("FAIL step_idle got pc=%0d want 0", o_pc_dbg); end
    for (int p = 1; p <= 4; p++) begin
      i_step = 1'b1;
      repeat (4) adv(1'b0);
      i_step = 1'b0;
      repeat (6) adv(1'b0);
      checks++; if (o_pc_dbg !== AW'(p)) begin
        errors++; $display("FAIL step_pulse%0d got pc=%0d want %0d", p, o_pc_dbg, p);
      end
    end
    checks++; if (o_halt !== 1'b1 || o_output !== 8'h0A) begin
      errors++; $display("FAIL step_final got halt=%b out=%h want 1 0a", o_halt, o_output);
    end
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    rst_n       = 1'b0;
    i_run       = 1'b0;
    i_prog_we   = 1'b0;
    i_prog_addr = '0;
    i_prog_data = '0;
    i_enter     = 1'b0;
    i_input     = '0;
    m_pc        = '0;
    m_a         = '0;
    m_halted    = 1'b0;
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
`ifdef SINGLE_STEP_EN
    i_step = 1'b0;
    test_reset();
    test_single_step();
`else
    test_reset();
    test_program_a();
    test_jz();
    test_sub_jpos();
    test_pc_wrap();
    test_input_abort();
    test_random_programs();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
